// File: rtl/pwm_cmp_bank.sv
// ---------------------------------------------------------------------------
// pwm_cmp_bank
//   Multi-channel PWM comparator bank driven by one shared prescaled counter.
//   Each channel holds start/end compare shadows (preloaded on the update
//   event or refreshed every cycle), produces registered eq/gt compare flags,
//   a windowed PWM output with polarity and wrap-around support, and a sticky
//   match flag. irq_o is the OR of all sticky flags.
//
// Ports
//   clk_psc_i           prescaler clock (single domain)
//   rst_n_i             asynchronous active-low reset
//   cnt_i               shared counter value
//   update_event_i      counter overflow / update event, 1-cycle pulse
//   cmp_start_i         start values, channel k at [k*WIDTH +: WIDTH]
//   cmp_end_i           end values, same packing
//   preload_en_i        1: shadow loads on update event only, 0: every cycle
//   ch_en_i             channel enable
//   pol_i               1: pwm_o is active-low
//   flag_clr_i          clear pulse for match_flag_o
//   cnt_eq/gt_cmp_*_o   registered compare flags against the shadows
//   pwm_o               registered PWM outputs
//   match_flag_o        sticky start/end match seen while running
//   irq_o               registered OR of match flags
//
// There is no valid/ready handshake in this block; every input is sampled
// on every clock edge and every output is a flop.
// ---------------------------------------------------------------------------
module pwm_cmp_bank #(
  parameter int CH_NUM = 16,
  parameter int WIDTH  = 16
) (
  input  logic                    clk_psc_i,
  input  logic                    rst_n_i,
  input  logic [WIDTH-1:0]        cnt_i,
  input  logic                    update_event_i,
  input  logic [CH_NUM*WIDTH-1:0] cmp_start_i,
  input  logic [CH_NUM*WIDTH-1:0] cmp_end_i,
  input  logic [CH_NUM-1:0]       preload_en_i,
  input  logic [CH_NUM-1:0]       ch_en_i,
  input  logic [CH_NUM-1:0]       pol_i,
  input  logic [CH_NUM-1:0]       flag_clr_i,
  output logic [CH_NUM-1:0]       cnt_eq_cmp_start_o,
  output logic [CH_NUM-1:0]       cnt_gt_cmp_start_o,
  output logic [CH_NUM-1:0]       cnt_eq_cmp_end_o,
  output logic [CH_NUM-1:0]       cnt_gt_cmp_end_o,
  output logic [CH_NUM-1:0]       pwm_o,
  output logic [CH_NUM-1:0]       match_flag_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {
    ST_DIS = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } ch_state_t;

  // Per-channel FSM state; this array is the observation point for checkers.
  ch_state_t        state_q [CH_NUM];
  ch_state_t        state_d [CH_NUM];

  logic [WIDTH-1:0] start_sh_q [CH_NUM];
  logic [WIDTH-1:0] end_sh_q   [CH_NUM];

  logic [CH_NUM-1:0] active;
  logic [CH_NUM-1:0] match_now;
  logic [CH_NUM-1:0] flag_d;

  // Next-state logic. A low enable always wins, including over an update
  // event in the same cycle. ARM waits for the period boundary so that a
  // channel never emits a partial first pulse.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      state_d[k] = state_q[k];
      if (!ch_en_i[k]) begin
        state_d[k] = ST_DIS;
      end else begin
        case (state_q[k])
          ST_DIS:  state_d[k] = ST_ARM;
          ST_ARM:  state_d[k] = update_event_i ? ST_RUN : ST_ARM;
          ST_RUN:  state_d[k] = ST_RUN;
          default: state_d[k] = ST_DIS;
        endcase
      end
    end
  end

  // Window decode against the shadows. start > end means the window wraps
  // through zero; start == end is an empty window (0% duty).
  always_comb begin
    active    = '0;
    match_now = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (start_sh_q[k] < end_sh_q[k]) begin
        active[k] = (cnt_i >= start_sh_q[k]) && (cnt_i < end_sh_q[k]);
      end else if (start_sh_q[k] > end_sh_q[k]) begin
        active[k] = (cnt_i >= start_sh_q[k]) || (cnt_i < end_sh_q[k]);
      end else begin
        active[k] = 1'b0;
      end
      match_now[k] = (state_q[k] == ST_RUN) &&
                     ((cnt_i == start_sh_q[k]) || (cnt_i == end_sh_q[k]));
    end
  end

  // A new match on the same cycle as a clear keeps the flag set.
  always_comb begin
    flag_d = match_now | (match_flag_o & ~flag_clr_i);
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k]    <= ST_DIS;
        start_sh_q[k] <= '0;
        end_sh_q[k]   <= '0;
      end
      cnt_eq_cmp_start_o <= '0;
      cnt_gt_cmp_start_o <= '0;
      cnt_eq_cmp_end_o   <= '0;
      cnt_gt_cmp_end_o   <= '0;
      pwm_o              <= '0;
      match_flag_o       <= '0;
      irq_o              <= 1'b0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        state_q[k] <= state_d[k];
        if (!preload_en_i[k] || update_event_i) begin
          start_sh_q[k] <= cmp_start_i[k*WIDTH +: WIDTH];
          end_sh_q[k]   <= cmp_end_i[k*WIDTH +: WIDTH];
        end
        cnt_eq_cmp_start_o[k] <= (cnt_i == start_sh_q[k]);
        cnt_gt_cmp_start_o[k] <= (cnt_i >  start_sh_q[k]);
        cnt_eq_cmp_end_o[k]   <= (cnt_i == end_sh_q[k]);
        cnt_gt_cmp_end_o[k]   <= (cnt_i >  end_sh_q[k]);
        // Gating with the live enable makes the output idle on the edge that
        // sees the enable drop, not one cycle later.
        pwm_o[k] <= ((state_q[k] == ST_RUN) && ch_en_i[k] && active[k]) ^ pol_i[k];
      end
      match_flag_o <= flag_d;
      irq_o        <= |flag_d;
    end
  end

endmodule

// File: tb/tb_pwm_cmp_bank.sv
// ---------------------------------------------------------------------------
// tb_pwm_cmp_bank
//   Directed bench for pwm_cmp_bank (CH_NUM=16, WIDTH=16). The bench drives a
//   0..99 counter with the update event on cnt=99. Channel roles:
//     ch0 preload window 10..20, end moved to 50 mid-period
//     ch1 immediate window 10..20, end moved to 30 at cnt=15
//     ch2 wrap window 90..10      ch3 sticky flag on start=5
//     ch4 empty window 40..40 pol=1  ch5 full window 0..100
//     ch6 enabled mid-period      ch7 pol=1, disabled in RUN
//     ch8 enable dropped on the update-event cycle
//   Outputs are sampled 1 time unit after the rising edge; prev holds the
//   counter value the sampled registered outputs correspond to.
// ---------------------------------------------------------------------------
module tb_pwm_cmp_bank;

  localparam int CH = 16;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst_n_i;
  logic [W-1:0]    cnt_i;
  logic            update_event_i;
  logic [CH*W-1:0] cmp_start_i;
  logic [CH*W-1:0] cmp_end_i;
  logic [CH-1:0]   preload_en_i;
  logic [CH-1:0]   ch_en_i;
  logic [CH-1:0]   pol_i;
  logic [CH-1:0]   flag_clr_i;
  logic [CH-1:0]   cnt_eq_cmp_start_o;
  logic [CH-1:0]   cnt_gt_cmp_start_o;
  logic [CH-1:0]   cnt_eq_cmp_end_o;
  logic [CH-1:0]   cnt_gt_cmp_end_o;
  logic [CH-1:0]   pwm_o;
  logic [CH-1:0]   match_flag_o;
  logic            irq_o;

  int checks   = 0;
  int failures = 0;
  int prev     = 0;

  pwm_cmp_bank #(.CH_NUM(CH), .WIDTH(W)) dut (
    .clk_psc_i          (clk),
    .rst_n_i            (rst_n_i),
    .cnt_i              (cnt_i),
    .update_event_i     (update_event_i),
    .cmp_start_i        (cmp_start_i),
    .cmp_end_i          (cmp_end_i),
    .preload_en_i       (preload_en_i),
    .ch_en_i            (ch_en_i),
    .pol_i              (pol_i),
    .flag_clr_i         (flag_clr_i),
    .cnt_eq_cmp_start_o (cnt_eq_cmp_start_o),
    .cnt_gt_cmp_start_o (cnt_gt_cmp_start_o),
    .cnt_eq_cmp_end_o   (cnt_eq_cmp_end_o),
    .cnt_gt_cmp_end_o   (cnt_gt_cmp_end_o),
    .pwm_o              (pwm_o),
    .match_flag_o       (match_flag_o),
    .irq_o              (irq_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (prev_cnt=%0d)", tag, got, exp, prev);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    prev = int'(cnt_i);
    cnt_i = (cnt_i == 16'd99) ? 16'd0 : cnt_i + 16'd1;
    update_event_i = (cnt_i == 16'd99);
  endtask

  task automatic set_ch(input int ch, input int s, input int e,
                        input logic pre, input logic en, input logic pl);
    cmp_start_i[ch*W +: W] = 16'(s);
    cmp_end_i[ch*W +: W]   = 16'(e);
    preload_en_i[ch]       = pre;
    ch_en_i[ch]            = en;
    pol_i[ch]              = pl;
  endtask

  function automatic logic in_win(input int c, input int s, input int e);
    return (c >= s) && (c < e);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_pwm"},  32'(pwm_o), 32'h0);
    check({tag, "_flag"}, 32'(match_flag_o), 32'h0);
    check({tag, "_irq"},  32'(irq_o), 32'h0);
    check({tag, "_eqs"},  32'(cnt_eq_cmp_start_o), 32'h0);
    check({tag, "_gts"},  32'(cnt_gt_cmp_start_o), 32'h0);
    check({tag, "_eqe"},  32'(cnt_eq_cmp_end_o), 32'h0);
    check({tag, "_gte"},  32'(cnt_gt_cmp_end_o), 32'h0);
  endtask

  initial begin
    rst_n_i        = 1'b0;
    cnt_i          = '0;
    update_event_i = 1'b0;
    cmp_start_i    = '0;
    cmp_end_i      = '0;
    preload_en_i   = '0;
    ch_en_i        = '0;
    pol_i          = '0;
    flag_clr_i     = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    set_ch(0, 10, 20,  1'b1, 1'b1, 1'b0);
    set_ch(1, 10, 20,  1'b0, 1'b1, 1'b0);
    set_ch(2, 90, 10,  1'b0, 1'b1, 1'b0);
    set_ch(3, 5,  200, 1'b0, 1'b1, 1'b0);
    set_ch(4, 40, 40,  1'b0, 1'b1, 1'b1);
    set_ch(5, 0,  100, 1'b0, 1'b1, 1'b0);
    set_ch(6, 0,  100, 1'b0, 1'b0, 1'b0);
    set_ch(7, 0,  100, 1'b0, 1'b1, 1'b1);
    set_ch(8, 0,  100, 1'b0, 1'b1, 1'b0);
    cnt_i = '0;
    @(negedge clk);
    rst_n_i = 1'b1;

    // Period A: every enabled channel is armed, no output pulses yet
    for (int i = 0; i < 100; i++) begin
      if (cnt_i == 16'd99) ch_en_i[8] = 1'b0;
      tick();
      check("A_pwm0", 32'(pwm_o[0]), 32'h0);
      check("A_pwm1", 32'(pwm_o[1]), 32'h0);
      check("A_pwm4", 32'(pwm_o[4]), 32'h1);
      check("A_pwm7", 32'(pwm_o[7]), 32'h1);
      check("A_pwm8", 32'(pwm_o[8]), 32'h0);
      check("A_eqs0", 32'(cnt_eq_cmp_start_o[0]), 32'(prev == 0));
      if (prev >= 1) check("A_eqs1", 32'(cnt_eq_cmp_start_o[1]), 32'(prev == 10));
      check("A_flag", 32'(match_flag_o), 32'h0);
      check("A_irq",  32'(irq_o), 32'h0);
    end

    // Period B: running; ch1 end changes at 15, ch0 end at 30 (preloaded)
    for (int i = 0; i < 100; i++) begin
      if (cnt_i == 16'd15) cmp_end_i[1*W +: W] = 16'd30;
      if (cnt_i == 16'd30) cmp_end_i[0*W +: W] = 16'd50;
      if (cnt_i == 16'd50) ch_en_i[6] = 1'b1;
      tick();
      check("B_pwm0", 32'(pwm_o[0]), 32'(in_win(prev, 10, 20)));
      check("B_eqs0", 32'(cnt_eq_cmp_start_o[0]), 32'(prev == 10));
      check("B_gts0", 32'(cnt_gt_cmp_start_o[0]), 32'(prev > 10));
      check("B_eqe0", 32'(cnt_eq_cmp_end_o[0]), 32'(prev == 20));
      check("B_gte0", 32'(cnt_gt_cmp_end_o[0]), 32'(prev > 20));
      check("B_pwm1", 32'(pwm_o[1]), 32'(in_win(prev, 10, 30)));
      check("B_eqe1", 32'(cnt_eq_cmp_end_o[1]), 32'(prev == 30));
      check("B_pwm2", 32'(pwm_o[2]), 32'((prev >= 90) || (prev < 10)));
      check("B_flag3", 32'(match_flag_o[3]), 32'(prev >= 5));
      check("B_pwm4", 32'(pwm_o[4]), 32'h1);
      check("B_pwm5", 32'(pwm_o[5]), 32'h1);
      check("B_pwm6", 32'(pwm_o[6]), 32'h0);
      check("B_pwm7", 32'(pwm_o[7]), 32'h0);
      check("B_pwm8", 32'(pwm_o[8]), 32'h0);
      check("B_irq",  32'(irq_o), 32'h1);
    end

    // Period C: new preloaded end, flag clear races, ch7 disabled at 60
    for (int i = 0; i < 100; i++) begin
      flag_clr_i[3] = (cnt_i == 16'd5) || (cnt_i == 16'd7);
      if (cnt_i == 16'd60) ch_en_i[7] = 1'b0;
      tick();
      check("C_pwm0", 32'(pwm_o[0]), 32'(in_win(prev, 10, 50)));
      check("C_eqe0", 32'(cnt_eq_cmp_end_o[0]), 32'(prev == 50));
      check("C_pwm1", 32'(pwm_o[1]), 32'(in_win(prev, 10, 30)));
      check("C_pwm2", 32'(pwm_o[2]), 32'((prev >= 90) || (prev < 10)));
      check("C_flag3", 32'(match_flag_o[3]), 32'(prev < 7));
      check("C_pwm5", 32'(pwm_o[5]), 32'h1);
      check("C_pwm6", 32'(pwm_o[6]), 32'h1);
      check("C_pwm7", 32'(pwm_o[7]), 32'(prev >= 60));
      check("C_flag7", 32'(match_flag_o[7]), 32'h1);
    end
    flag_clr_i = '0;

    // Period D: asynchronous reset mid-pulse at cnt=20
    while (cnt_i != 16'd20) tick();
    #3;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick();
    tick();
    check("rst_hold_pwm", 32'(pwm_o), 32'h0);
    @(negedge clk);
    rst_n_i = 1'b1;
    do begin
      tick();
      check("D_pwm_idle", 32'(pwm_o), 32'h0090);
      check("D_gte0", 32'(cnt_gt_cmp_end_o[0]), 32'h1);
      check("D_eqs0", 32'(cnt_eq_cmp_start_o[0]), 32'h0);
    end while (cnt_i != 16'd0);

    // Period E: channels re-armed through the update event
    for (int i = 0; i < 60; i++) begin
      tick();
      check("E_pwm0", 32'(pwm_o[0]), 32'(in_win(prev, 10, 50)));
      check("E_pwm4", 32'(pwm_o[4]), 32'h1);
      check("E_pwm5", 32'(pwm_o[5]), 32'h1);
      check("E_pwm7", 32'(pwm_o[7]), 32'h1);
    end

    // Disable everything and clear all flags where no channel matches
    while (cnt_i != 16'd70) tick();
    ch_en_i    = '0;
    flag_clr_i = '1;
    tick();
    flag_clr_i = '0;
    tick();
    check("end_flag", 32'(match_flag_o), 32'h0);
    check("end_irq",  32'(irq_o), 32'h0);
    check("end_pwm",  32'(pwm_o), 32'h0090);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
